// File: rtl/ariane_pkg.sv
// Minimal scoreboard entry type shared by decode, the issue queue and the reorder stage.
package ariane_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
  } scoreboard_entry_t;

endpackage

// File: rtl/issue_fifo_if.sv
// Decode-to-issue-queue-to-reorder signal bundle.
// Handshakes: decode offers an entry with decoded_entry_valid_i and it is taken only in a cycle where
// decoded_entry_ack_o is also high; the head is taken when issue_entry_valid_o and issue_instr_ack_i are both high.
interface issue_fifo_if #(
    parameter int unsigned DEPTH = 4
);
    import ariane_pkg::*;

    logic                     flush_i;
    logic                     debug_req_i;
    scoreboard_entry_t        decoded_entry_i;
    logic                     decoded_entry_valid_i;
    logic                     is_ctrl_flow_i;
    logic                     decoded_entry_ack_o;
    scoreboard_entry_t        issue_entry_o;
    logic                     issue_entry_valid_o;
    logic                     is_ctrl_flow_o;
    logic                     issue_instr_ack_i;
    scoreboard_entry_t        peek_entry_o;
    logic                     peek_valid_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport slave (
        input  flush_i, debug_req_i, decoded_entry_i, decoded_entry_valid_i, is_ctrl_flow_i,
               issue_instr_ack_i,
        output decoded_entry_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
               peek_entry_o, peek_valid_o, count_o
    );

    modport master (
        output flush_i, debug_req_i, decoded_entry_i, decoded_entry_valid_i, is_ctrl_flow_i,
               issue_instr_ack_i,
        input  decoded_entry_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
               peek_entry_o, peek_valid_o, count_o
    );

endinterface

// File: rtl/issue_fifo.sv
// Circular queue of decoded scoreboard entries feeding instr_reorder with head plus one-entry lookahead.
// A queued control-flow entry blocks further pushes until it has been issued.
module issue_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    issue_fifo_if.slave  bus
);
    import ariane_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    typedef struct packed {
        scoreboard_entry_t entry;
        logic              cf;
    } slot_t;

    slot_t         mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
    logic [AW:0]   count_q, cf_cnt_q;
    logic          ctrl_hold;
    logic          push, pop;

    assign rd_ptr_nxt = rd_ptr_q + AW'(1);
    assign ctrl_hold  = (cf_cnt_q != '0);

    // Ack is deliberately independent of the pop side, so a full queue never accepts.
    assign bus.decoded_entry_ack_o = (count_q < FULL) & ~ctrl_hold & ~bus.debug_req_i & ~bus.flush_i;
    assign bus.issue_entry_valid_o = (count_q != '0) & ~bus.flush_i;
    assign bus.peek_valid_o        = (count_q > ONE) & ~bus.flush_i;
    assign bus.issue_entry_o       = mem_q[rd_ptr_q].entry;
    assign bus.is_ctrl_flow_o      = mem_q[rd_ptr_q].cf;
    assign bus.peek_entry_o        = mem_q[rd_ptr_nxt].entry;
    assign bus.count_o             = count_q;

    assign push = bus.decoded_entry_valid_i & bus.decoded_entry_ack_o;
    assign pop  = bus.issue_entry_valid_o & bus.issue_instr_ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cf_cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (bus.flush_i) begin
            // Storage is left as is; only the bookkeeping is cleared.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cf_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{entry: bus.decoded_entry_i, cf: bus.is_ctrl_flow_i};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count_q <= count_q + ONE;
                2'b01:   count_q <= count_q - ONE;
                default: count_q <= count_q;
            endcase
            case ({push & bus.is_ctrl_flow_i, pop & bus.is_ctrl_flow_o})
                2'b10:   cf_cnt_q <= cf_cnt_q + ONE;
                2'b01:   cf_cnt_q <= cf_cnt_q - ONE;
                default: cf_cnt_q <= cf_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_fifo.sv
// Bench for issue_fifo: queue-based reference model checked every cycle, directed scenarios plus random traffic.
module tb_issue_fifo;
    import ariane_pkg::*;

    localparam int DEPTH = 4;
    localparam int EW = $bits(scoreboard_entry_t);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_fifo_if #(.DEPTH(DEPTH)) bus ();

    issue_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    // Model: each element is {ctrl_flow_bit, entry}, head at index 0.
    logic [EW:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic seen_ack, seen_valid, seen_peek_valid;
    logic [$clog2(DEPTH):0] seen_count;
    scoreboard_entry_t seen_peek, seen_head;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic scoreboard_entry_t rand_entry();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return scoreboard_entry_t'(r[EW-1:0]);
    endfunction

    function automatic logic model_hold();
        foreach (exp_q[i]) if (exp_q[i][EW]) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle of inputs, check every output against the model at the falling edge,
    // then advance the model at the rising edge.
    task automatic step(input logic v, input logic cf, input scoreboard_entry_t e,
                        input logic iack, input logic fl, input logic dbg);
        logic e_ack, e_valid, e_peek, do_push, do_pop;
        bus.decoded_entry_valid_i = v;
        bus.is_ctrl_flow_i        = cf;
        bus.decoded_entry_i       = e;
        bus.issue_instr_ack_i     = iack;
        bus.flush_i               = fl;
        bus.debug_req_i           = dbg;
        @(negedge clk);
        e_ack   = (exp_q.size() < DEPTH) && !model_hold() && !dbg && !fl;
        e_valid = (exp_q.size() != 0) && !fl;
        e_peek  = (exp_q.size() >= 2) && !fl;
        chk("ack", bus.decoded_entry_ack_o, e_ack);
        chk("valid", bus.issue_entry_valid_o, e_valid);
        chk("peek_valid", bus.peek_valid_o, e_peek);
        chk("count", bus.count_o, exp_q.size());
        if (e_valid) begin
            chk("head_entry", bus.issue_entry_o, exp_q[0][EW-1:0]);
            chk("head_cf", bus.is_ctrl_flow_o, exp_q[0][EW]);
        end
        if (e_peek) chk("peek_entry", bus.peek_entry_o, exp_q[1][EW-1:0]);
        seen_ack        = bus.decoded_entry_ack_o;
        seen_valid      = bus.issue_entry_valid_o;
        seen_peek_valid = bus.peek_valid_o;
        seen_count      = bus.count_o;
        seen_peek       = bus.peek_entry_o;
        seen_head       = bus.issue_entry_o;
        do_push = v && e_ack;
        do_pop  = e_valid && iack;
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({cf, e});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    scoreboard_entry_t ents[5];
    scoreboard_entry_t ea;

    initial begin
        bus.decoded_entry_valid_i = 1'b0;
        bus.is_ctrl_flow_i        = 1'b0;
        bus.decoded_entry_i       = '0;
        bus.issue_instr_ack_i     = 1'b0;
        bus.flush_i               = 1'b0;
        bus.debug_req_i           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_head_zero", bus.issue_entry_o, '0);
        chk("rst_peek_zero", bus.peek_entry_o, '0);
        chk("rst_cf", bus.is_ctrl_flow_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill/drain: 5 pushes into an idle queue, only 4 accepted.
        for (int i = 0; i < 5; i++) begin
            ents[i] = rand_entry();
            step(1'b1, 1'b0, ents[i], 1'b0, 1'b0, 1'b0);
            chk("fill_ack", seen_ack, (i < 4) ? 1'b1 : 1'b0);
        end
        chk("fill_count", seen_count, 4);
        chk("fill_peek_is_2nd", seen_peek, ents[1]);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("drain_order", seen_head, ents[i]);
        end
        idle();
        chk("drain_count", seen_count, 0);

        // Streaming with wrap: occupancy settles at 1.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, rand_entry(), 1'b1, 1'b0, 1'b0);
            if (i > 0) chk("stream_count", seen_count, 1);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Ctrl hold: branch B then ALU A.
        step(1'b1, 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
        chk("cf_push_ack", seen_ack, 1'b1);
        ea = rand_entry();
        step(1'b1, 1'b0, ea, 1'b0, 1'b0, 1'b0);
        chk("cf_hold_ack", seen_ack, 1'b0);
        step(1'b1, 1'b0, ea, 1'b1, 1'b0, 1'b0);
        chk("cf_pop_cycle_ack", seen_ack, 1'b0);
        step(1'b1, 1'b0, ea, 1'b0, 1'b0, 1'b0);
        chk("cf_release_ack", seen_ack, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with 3 queued plus a same-cycle push and pop.
        repeat (3) step(1'b1, 1'b0, rand_entry(), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, rand_entry(), 1'b1, 1'b1, 1'b0);
        chk("flush_ack", seen_ack, 1'b0);
        chk("flush_valid", seen_valid, 1'b0);
        step(1'b1, 1'b0, rand_entry(), 1'b0, 1'b0, 1'b0);
        chk("post_flush_count", seen_count, 0);
        chk("post_flush_valid", seen_valid, 1'b0);
        chk("post_flush_ack", seen_ack, 1'b1);

        // Debug request blocks pushes but not the drain.
        step(1'b1, 1'b0, rand_entry(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, rand_entry(), 1'b1, 1'b0, 1'b1);
            chk("dbg_ack", seen_ack, 1'b0);
            chk("dbg_drain_valid", seen_valid, (i < 2) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset with 3 entries and a branch queued.
        repeat (2) step(1'b1, 1'b0, rand_entry(), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
        bus.decoded_entry_valid_i = 1'b0;
        bus.issue_instr_ack_i     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.issue_entry_valid_o, 1'b0);
        chk("arst_peek_valid", bus.peek_valid_o, 1'b0);
        chk("arst_count", bus.count_o, 0);
        chk("arst_cf", bus.is_ctrl_flow_o, 1'b0);
        chk("arst_head", bus.issue_entry_o, '0);
        chk("arst_peek", bus.peek_entry_o, '0);
        chk("arst_ack", bus.decoded_entry_ack_o, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, rand_entry(), 1'b0, 1'b0, 1'b0);
        chk("post_rst_push_ack", seen_ack, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 19) < 3, rand_entry(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
